main_state_machine: RTL and testbench
=====================================

// Module: main_state_machine
// PURPOSE
//  Top-level sequencer of the conv accelerator; produces `state` and `msg` for main_state_actions.
//  Waits for a start command from the control core (cc), then runs one job:
//  load OFM tile, then N x (load IFM, load weight, conv), then write back the OFM tile.
//  Reports completion or error to cc through the DEBUG state and `msg`.
// PARAMETERS
//  TILE_CNT_W  8        width of the input-tile count/counter
//  TIMEOUT     2**20    max cycles in any LOAD_*/CONV/WRITE_BACK state before error
//  TO_W        21       watchdog counter width; must hold TIMEOUT
// PORTS
//  clk           in   1              system clock
//  rst_n         in   1              asynchronous active-low reset
//  from_cc       in   8              command byte: 8'h00 idle, 8'h01 start, 8'h02 debug peek, 8'hFF abort
//  num_in_tiles  in   TILE_CNT_W     IFM/weight tiles to accumulate per job; sampled at start
//  ol_done       in   1              1-cycle pulse: OFM load complete
//  il_done       in   1              1-cycle pulse: IFM load complete
//  wl_done       in   1              1-cycle pulse: weight load complete
//  conv_done     in   1              1-cycle pulse: convolution pass complete
//  ow_done       in   1              1-cycle pulse: OFM write-back complete
//  state         out  NUM_STATES_W   current state code (shared state defines)
//  msg           out  8              status byte, shown to cc in DEBUG
//  tiles_done    out  TILE_CNT_W     conv passes completed in the current job
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=WAIT_FOR_CC, msg=0, tiles_done=0, watchdog=0, tile target reg=0.
//  - state is a registered output. Every transition takes effect on the clk edge after its condition.
//  - WAIT_FOR_CC:
//    - from_cc==01: latch num_in_tiles, clear tiles_done and msg, go to INIT_LOAD_OFM.
//    - from_cc==02: go to DEBUG; msg unchanged.
//    - Any other code: stay.
//  - Each INIT_* state lasts exactly 1 cycle, then enters its LOAD_*/CONV/WRITE_BACK state.
//    A done pulse seen during an INIT_* cycle is ignored.
//  - LOAD_OFM + ol_done:
//    - Latched count==0: go to INIT_WRITE_BACK.
//    - Otherwise: go to INIT_LOAD_IFM.
//  - LOAD_IFM + il_done: go to INIT_LOAD_WEIGHT.
//  - LOAD_WEIGHT + wl_done: go to INIT_CONV.
//  - CONV + conv_done: tiles_done += 1.
//    - If the new value == latched count: go to INIT_WRITE_BACK.
//    - Otherwise: go to INIT_LOAD_IFM.
//  - WRITE_BACK + ow_done: msg = {1'b1 (done), 1'b0, tiles_done[5:0]}; go to DEBUG.
//  - DEBUG: hold until from_cc==00, then go to WAIT_FOR_CC. msg holds its value.
//  - Done pulses for a unit other than the active one are ignored; they never advance state.
//  - Watchdog:
//    - Counter clears on every state change.
//    - Counter increments while in LOAD_OFM/LOAD_IFM/LOAD_WEIGHT/CONV/WRITE_BACK.
//    - On reaching TIMEOUT: msg = {1'b0, 1'b1 (error), state[5:0]}; go to DEBUG.
//  - Abort: from_cc==FF in any state other than WAIT_FOR_CC or DEBUG:
//    - Next state = DEBUG; msg = {2'b01, 6'h3F}.
//    - Abort has priority over a done pulse in the same cycle.
//  - Done and timeout reached in the same cycle: done wins.
//  - tiles_done saturates at its max; it cannot wrap because it never exceeds the latched count.
//  - Unknown state code: go to WAIT_FOR_CC next cycle.
//  - Reset mid-job: immediate return to WAIT_FOR_CC. Downstream units see the INIT enables drop
//    via main_state_actions.
// STRUCTURE
//  - Shared defines header (same header main_state_actions uses):
//    - state codes and `NUM_STATES_W
//    - cc command codes CC_IDLE/CC_START/CC_DEBUG/CC_ABORT
//    - msg bit positions MSG_DONE=7, MSG_ERR=6
//  - One sub-module: phase_watchdog. Inputs: clk, rst_n, clear, run. Output: expired.
//    Parameterised by TIMEOUT and TO_W.
//  - Registered next-state logic; no combinational path from inputs to state.
// TESTING
//  1. Reset, then start with num_in_tiles=3, done pulses 5 cycles after each INIT.
//     Expect: OFM, then 3x(IFM, WEIGHT, CONV), then WRITE_BACK, DEBUG with msg=8'h83.
//     from_cc=00 returns to WAIT_FOR_CC.
//  2. num_in_tiles=0. Expect: LOAD_OFM goes straight to INIT_WRITE_BACK, final msg=8'h80,
//     and INIT_LOAD_IFM never appears.
//  3. TIMEOUT=64, withhold wl_done. Expect: 64 cycles in LOAD_WEIGHT, then DEBUG with msg
//     bit6=1 and msg[5:0]=LOAD_WEIGHT code.
//  4. Abort in CONV with conv_done in the same cycle. Expect: DEBUG with msg=8'h7F;
//     tiles_done unchanged.
//  5. Stray done pulses: il_done in LOAD_OFM, conv_done during INIT_CONV.
//     Expect: state unchanged, no skipped phase.
//  6. Drop rst_n asynchronously mid-LOAD_IFM. Expect: state=WAIT_FOR_CC before the next clk
//     edge; msg=0 and tiles_done=0.

Source files
------------

// File: rtl/main_state_machine_pkg.sv
// Shared definitions for the conv accelerator sequencer: state codes, cc commands, msg bit positions.
package main_state_machine_pkg;

  localparam int NUM_STATES_W = 6;

  typedef enum logic [NUM_STATES_W-1:0] {
    ST_WAIT_FOR_CC      = 6'd0,
    ST_INIT_LOAD_OFM    = 6'd1,
    ST_LOAD_OFM         = 6'd2,
    ST_INIT_LOAD_IFM    = 6'd3,
    ST_LOAD_IFM         = 6'd4,
    ST_INIT_LOAD_WEIGHT = 6'd5,
    ST_LOAD_WEIGHT      = 6'd6,
    ST_INIT_CONV        = 6'd7,
    ST_CONV             = 6'd8,
    ST_INIT_WRITE_BACK  = 6'd9,
    ST_WRITE_BACK       = 6'd10,
    ST_DEBUG            = 6'd11
  } state_e;

  localparam logic [7:0] CC_IDLE  = 8'h00;
  localparam logic [7:0] CC_START = 8'h01;
  localparam logic [7:0] CC_DEBUG = 8'h02;
  localparam logic [7:0] CC_ABORT = 8'hFF;

  localparam int MSG_DONE = 7;
  localparam int MSG_ERR  = 6;

  // States where a unit is busy and the watchdog runs.
  function automatic logic is_active(state_e s);
    return s inside {ST_LOAD_OFM, ST_LOAD_IFM, ST_LOAD_WEIGHT, ST_CONV, ST_WRITE_BACK};
  endfunction

  function automatic logic is_init(state_e s);
    return s inside {ST_INIT_LOAD_OFM, ST_INIT_LOAD_IFM, ST_INIT_LOAD_WEIGHT,
                     ST_INIT_CONV, ST_INIT_WRITE_BACK};
  endfunction

endpackage

// File: rtl/main_state_machine_phase_watchdog.sv
// Per-phase cycle watchdog: counts while run is high, flags expiry on the TIMEOUT-th cycle.
module phase_watchdog #(
  parameter int TIMEOUT = 2**20,
  parameter int TO_W    = 21
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam logic [TO_W-1:0] LAST = TO_W'(TIMEOUT - 1);

  logic [TO_W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (run && (cnt != LAST)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign expired = run && (cnt == LAST);

endmodule

// File: rtl/main_state_machine.sv
// Top-level job sequencer of the conv accelerator: OFM load, N x (IFM, weight, conv), write-back.
//
// state               | meaning
// WAIT_FOR_CC         | idle, waiting for a cc command
// INIT_<phase>        | one-cycle enable pulse for the next unit
// LOAD_OFM/IFM/WEIGHT | waiting for the corresponding load unit
// CONV                | waiting for a convolution pass
// WRITE_BACK          | waiting for OFM write-back
// DEBUG               | result/error shown in msg, held until cc sends idle
module main_state_machine
  import main_state_machine_pkg::*;
#(
  parameter int TILE_CNT_W = 8,
  parameter int TIMEOUT    = 2**20,
  parameter int TO_W       = 21
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [7:0]              from_cc,
  input  logic [TILE_CNT_W-1:0]   num_in_tiles,
  input  logic                    ol_done,
  input  logic                    il_done,
  input  logic                    wl_done,
  input  logic                    conv_done,
  input  logic                    ow_done,
  output logic [NUM_STATES_W-1:0] state,
  output logic [7:0]              msg,
  output logic [TILE_CNT_W-1:0]   tiles_done
);

  state_e                state_q, state_d;
  logic [7:0]            msg_q, msg_d;
  logic [TILE_CNT_W-1:0] tiles_q, tiles_d;
  logic [TILE_CNT_W-1:0] target_q, target_d;
  logic [TILE_CNT_W-1:0] tiles_inc;
  logic                  active_done;
  logic                  abort_hit;
  logic                  run;
  logic                  clear;
  logic                  expired;

  assign run       = is_active(state_q);
  assign clear     = (state_d != state_q);
  assign abort_hit = (from_cc == CC_ABORT) && (is_active(state_q) || is_init(state_q));
  assign tiles_inc = (&tiles_q) ? tiles_q : tiles_q + 1'b1;

  always_comb begin
    active_done = 1'b0;
    case (state_q)
      ST_LOAD_OFM:    active_done = ol_done;
      ST_LOAD_IFM:    active_done = il_done;
      ST_LOAD_WEIGHT: active_done = wl_done;
      ST_CONV:        active_done = conv_done;
      ST_WRITE_BACK:  active_done = ow_done;
      default:        active_done = 1'b0;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    msg_d    = msg_q;
    tiles_d  = tiles_q;
    target_d = target_q;
    case (state_q)
      ST_WAIT_FOR_CC: begin
        if (from_cc == CC_START) begin
          target_d = num_in_tiles;
          tiles_d  = '0;
          msg_d    = '0;
          state_d  = ST_INIT_LOAD_OFM;
        end else if (from_cc == CC_DEBUG) begin
          state_d = ST_DEBUG;
        end
      end
      ST_INIT_LOAD_OFM:    state_d = ST_LOAD_OFM;
      ST_INIT_LOAD_IFM:    state_d = ST_LOAD_IFM;
      ST_INIT_LOAD_WEIGHT: state_d = ST_LOAD_WEIGHT;
      ST_INIT_CONV:        state_d = ST_CONV;
      ST_INIT_WRITE_BACK:  state_d = ST_WRITE_BACK;
      ST_LOAD_OFM: begin
        if (ol_done) state_d = (target_q == '0) ? ST_INIT_WRITE_BACK : ST_INIT_LOAD_IFM;
      end
      ST_LOAD_IFM: begin
        if (il_done) state_d = ST_INIT_LOAD_WEIGHT;
      end
      ST_LOAD_WEIGHT: begin
        if (wl_done) state_d = ST_INIT_CONV;
      end
      ST_CONV: begin
        if (conv_done) begin
          tiles_d = tiles_inc;
          state_d = (tiles_inc == target_q) ? ST_INIT_WRITE_BACK : ST_INIT_LOAD_IFM;
        end
      end
      ST_WRITE_BACK: begin
        if (ow_done) begin
          msg_d   = {1'b1, 1'b0, tiles_q[5:0]};
          state_d = ST_DEBUG;
        end
      end
      ST_DEBUG: begin
        if (from_cc == CC_IDLE) state_d = ST_WAIT_FOR_CC;
      end
      default: state_d = ST_WAIT_FOR_CC;
    endcase

    // Precedence: abort over done over timeout.
    if (expired && !active_done) begin
      msg_d   = {1'b0, 1'b1, state_q[5:0]};
      state_d = ST_DEBUG;
    end
    if (abort_hit) begin
      msg_d   = {2'b01, 6'h3F};
      tiles_d = tiles_q;
      state_d = ST_DEBUG;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_WAIT_FOR_CC;
      msg_q    <= '0;
      tiles_q  <= '0;
      target_q <= '0;
    end else begin
      state_q  <= state_d;
      msg_q    <= msg_d;
      tiles_q  <= tiles_d;
      target_q <= target_d;
    end
  end

  phase_watchdog #(
    .TIMEOUT (TIMEOUT),
    .TO_W    (TO_W)
  ) u_watchdog (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (clear),
    .run     (run),
    .expired (expired)
  );

  assign state      = state_q;
  assign msg        = msg_q;
  assign tiles_done = tiles_q;

endmodule

// File: tb/tb_main_state_machine.sv
// Self-checking bench for main_state_machine: phase-list job model with random latencies and stray pulses.
module tb_main_state_machine;
  import main_state_machine_pkg::*;

  localparam int TW = 8;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic [7:0]              from_cc;
  logic [TW-1:0]           num_in_tiles;
  logic [4:0]              done_vec;
  logic                    ol_done, il_done, wl_done, conv_done, ow_done;
  logic [NUM_STATES_W-1:0] state;
  logic [7:0]              msg;
  logic [TW-1:0]           tiles_done;

  int vectors = 0;
  int errors  = 0;
  int phases[$];

  // done_vec index = phase: 0 OFM load, 1 IFM load, 2 weight load, 3 conv, 4 write-back
  assign {ow_done, conv_done, wl_done, il_done, ol_done} = done_vec;

  always #5 clk = ~clk;

  main_state_machine #(
    .TILE_CNT_W (TW),
    .TIMEOUT    (64),
    .TO_W       (21)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .from_cc      (from_cc),
    .num_in_tiles (num_in_tiles),
    .ol_done      (ol_done),
    .il_done      (il_done),
    .wl_done      (wl_done),
    .conv_done    (conv_done),
    .ow_done      (ow_done),
    .state        (state),
    .msg          (msg),
    .tiles_done   (tiles_done)
  );

  function automatic logic [5:0] init_code(int p);
    case (p)
      0: return ST_INIT_LOAD_OFM;
      1: return ST_INIT_LOAD_IFM;
      2: return ST_INIT_LOAD_WEIGHT;
      3: return ST_INIT_CONV;
      default: return ST_INIT_WRITE_BACK;
    endcase
  endfunction

  function automatic logic [5:0] busy_code(int p);
    case (p)
      0: return ST_LOAD_OFM;
      1: return ST_LOAD_IFM;
      2: return ST_LOAD_WEIGHT;
      3: return ST_CONV;
      default: return ST_WRITE_BACK;
    endcase
  endfunction

  task automatic tick();
    @(negedge clk);
  endtask

  // Reference job: OFM, n x (IFM, weight, conv), write-back.
  task automatic build_phases(input int n);
    phases = {};
    phases.push_back(0);
    for (int t = 0; t < n; t++) begin
      phases.push_back(1);
      phases.push_back(2);
      phases.push_back(3);
    end
    phases.push_back(4);
  endtask

  // Starts a job and walks the phase list; stops inside phase stop_idx if it exists,
  // otherwise completes the job and checks the DEBUG result.
  task automatic run_job(input int n, input int stop_idx, input bit strays);
    int convs;
    int d;
    int other;
    int p;
    convs = 0;
    build_phases(n);
    from_cc      = CC_START;
    num_in_tiles = TW'(n);
    tick();
    num_in_tiles = TW'($urandom_range(0, 255));
    for (int i = 0; i < phases.size(); i++) begin
      p = phases[i];
      vectors++;
      if (state !== init_code(p)) begin
        errors++;
        $display("FAIL init_phase%0d: state=%0d expected=%0d", i, state, init_code(p));
      end
      if (strays && ($urandom_range(0, 1) == 1)) done_vec[p] = 1'b1;
      tick();
      done_vec = '0;
      vectors++;
      if (state !== busy_code(p)) begin
        errors++;
        $display("FAIL enter_phase%0d: state=%0d expected=%0d", i, state, busy_code(p));
      end
      if (i == stop_idx) return;
      d = $urandom_range(0, 6);
      for (int k = 0; k < d; k++) begin
        if (strays) begin
          other = $urandom_range(0, 4);
          if (other != p) done_vec[other] = 1'b1;
        end
        tick();
        done_vec = '0;
        vectors++;
        if (state !== busy_code(p)) begin
          errors++;
          $display("FAIL hold_phase%0d: state=%0d expected=%0d", i, state, busy_code(p));
        end
      end
      done_vec[p] = 1'b1;
      tick();
      done_vec = '0;
      if (p == 3) convs++;
      vectors++;
      if (tiles_done !== TW'(convs)) begin
        errors++;
        $display("FAIL tiles_phase%0d: tiles_done=%0d expected=%0d", i, tiles_done, convs);
      end
    end
    vectors++;
    if (state !== ST_DEBUG) begin
      errors++;
      $display("FAIL job_end_state: state=%0d expected=%0d", state, ST_DEBUG);
    end
    vectors++;
    if (msg !== (8'h80 | 8'(n % 64))) begin
      errors++;
      $display("FAIL job_msg: msg=%02h expected=%02h", msg, 8'h80 | 8'(n % 64));
    end
  endtask

  task automatic finish_debug();
    tick();
    vectors++;
    if (state !== ST_DEBUG) begin
      errors++;
      $display("FAIL debug_hold: state=%0d expected=%0d", state, ST_DEBUG);
    end
    from_cc = CC_IDLE;
    tick();
    vectors++;
    if (state !== ST_WAIT_FOR_CC) begin
      errors++;
      $display("FAIL debug_exit: state=%0d expected=%0d", state, ST_WAIT_FOR_CC);
    end
  endtask

  task automatic test_reset();
    rst_n        = 1'b0;
    from_cc      = CC_IDLE;
    num_in_tiles = '0;
    done_vec     = '0;
    tick();
    tick();
    vectors++;
    if (state !== ST_WAIT_FOR_CC || msg !== 8'h00 || tiles_done !== '0) begin
      errors++;
      $display("FAIL reset: state=%0d msg=%02h tiles=%0d expected 0/00/0", state, msg, tiles_done);
    end
    rst_n   = 1'b1;
    from_cc = 8'h55;
    done_vec = 5'b11111;
    tick();
    done_vec = '0;
    vectors++;
    if (state !== ST_WAIT_FOR_CC) begin
      errors++;
      $display("FAIL wait_ignores: state=%0d expected=%0d", state, ST_WAIT_FOR_CC);
    end
    from_cc = CC_IDLE;
  endtask

  task automatic test_debug_peek(input logic [7:0] exp_msg);
    from_cc = CC_DEBUG;
    tick();
    vectors++;
    if (state !== ST_DEBUG || msg !== exp_msg) begin
      errors++;
      $display("FAIL debug_peek: state=%0d msg=%02h expected %0d/%02h", state, msg, ST_DEBUG, exp_msg);
    end
    from_cc = CC_IDLE;
    tick();
    vectors++;
    if (state !== ST_WAIT_FOR_CC) begin
      errors++;
      $display("FAIL debug_peek_exit: state=%0d expected=%0d", state, ST_WAIT_FOR_CC);
    end
  endtask

  task automatic test_timeout();
    int cycles;
    run_job(1, 2, 1'b0);
    cycles = 1;
    for (int k = 0; k < 200 && state === ST_LOAD_WEIGHT; k++) begin
      tick();
      if (state === ST_LOAD_WEIGHT) cycles++;
    end
    vectors++;
    if (cycles != 64) begin
      errors++;
      $display("FAIL timeout_cycles: cycles=%0d expected=64", cycles);
    end
    vectors++;
    if (state !== ST_DEBUG || msg !== (8'h40 | 8'(ST_LOAD_WEIGHT))) begin
      errors++;
      $display("FAIL timeout_msg: state=%0d msg=%02h expected %0d/%02h",
               state, msg, ST_DEBUG, 8'h40 | 8'(ST_LOAD_WEIGHT));
    end
    from_cc = CC_START;
    finish_debug();
  endtask

  task automatic test_abort();
    int n;
    int pass;
    n    = $urandom_range(2, 4);
    pass = $urandom_range(1, n);
    run_job(n, 3 * pass, 1'b1);
    from_cc     = CC_ABORT;
    done_vec[3] = 1'b1;
    tick();
    done_vec = '0;
    vectors++;
    if (state !== ST_DEBUG || msg !== 8'h7F) begin
      errors++;
      $display("FAIL abort: state=%0d msg=%02h expected %0d/7f", state, msg, ST_DEBUG);
    end
    vectors++;
    if (tiles_done !== TW'(pass - 1)) begin
      errors++;
      $display("FAIL abort_tiles: tiles_done=%0d expected=%0d", tiles_done, pass - 1);
    end
    finish_debug();
    from_cc = CC_ABORT;
    tick();
    vectors++;
    if (state !== ST_WAIT_FOR_CC) begin
      errors++;
      $display("FAIL abort_in_wait: state=%0d expected=%0d", state, ST_WAIT_FOR_CC);
    end
    from_cc = CC_IDLE;
  endtask

  task automatic test_stray();
    run_job(1, 0, 1'b0);
    done_vec[1] = 1'b1;
    tick();
    done_vec = '0;
    vectors++;
    if (state !== ST_LOAD_OFM) begin
      errors++;
      $display("FAIL stray_il_in_ofm: state=%0d expected=%0d", state, ST_LOAD_OFM);
    end
    done_vec[0] = 1'b1;
    tick();
    done_vec[0] = 1'b0;
    done_vec[1] = 1'b1;
    tick();
    done_vec = '0;
    vectors++;
    if (state !== ST_LOAD_IFM) begin
      errors++;
      $display("FAIL stray_il_in_init: state=%0d expected=%0d", state, ST_LOAD_IFM);
    end
    tick();
    vectors++;
    if (state !== ST_LOAD_IFM) begin
      errors++;
      $display("FAIL stray_no_skip: state=%0d expected=%0d", state, ST_LOAD_IFM);
    end
    from_cc = CC_ABORT;
    tick();
    finish_debug();
  endtask

  task automatic test_reset_mid_job();
    run_job(2, 4, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (state !== ST_WAIT_FOR_CC || msg !== 8'h00 || tiles_done !== '0) begin
      errors++;
      $display("FAIL async_reset: state=%0d msg=%02h tiles=%0d expected 0/00/0", state, msg, tiles_done);
    end
    from_cc = CC_IDLE;
    tick();
    rst_n = 1'b1;
    tick();
    vectors++;
    if (state !== ST_WAIT_FOR_CC) begin
      errors++;
      $display("FAIL after_reset: state=%0d expected=%0d", state, ST_WAIT_FOR_CC);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    for (int j = 0; j < 4; j++) begin
      n = $urandom_range(0, 5);
      run_job(n, 1000, 1'b1);
      finish_debug();
    end
  endtask

  initial begin
    test_reset();
    test_debug_peek(8'h00);
    run_job(3, 1000, 1'b0);
    finish_debug();
    run_job(0, 1000, 1'b0);
    finish_debug();
    test_debug_peek(8'h80);
    test_timeout();
    test_abort();
    test_stray();
    test_reset_mid_job();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_time_limit: bench still running, expected to finish");
    $fatal(1);
  end

endmodule
